// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit
//   Memory-stage access unit. Turns one load/store request from the pipeline
//   into a single-beat AXI read or write, then returns size-formatted,
//   sign/zero-extended load data together with a one-cycle done pulse.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   memory_enable         request valid (level, held until memory_done)
//   mem_read, mem_write   load / store select (load wins if both are set)
//   mem_size              0 byte, 1 half, 2 word, 3 double
//   mem_unsigned          zero-extend loads
//   alu_data              effective address
//   reg_b_contents        store data, right-aligned
//   loaded_data_out       extended load result (0 after a store or no-op)
//   memory_done           one-cycle completion pulse
//   mem_error             misaligned, illegal size or non-OKAY response
//   m_axi_ar*/r*/aw*/w*/b* single-beat AXI master channels
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for memory_enable, latches the request on accept
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for the read beat
// WR_REQ  | awvalid/wvalid high, each dropped after its own ready
// WR_RESP | bready high, waiting for the write response
// DONE  | memory_done pulse, back to IDLE
module mem_access_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_enable,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [ADDR_WIDTH-1:0] alu_data,
  input  logic [DATA_WIDTH-1:0] reg_b_contents,
  output logic [DATA_WIDTH-1:0] loaded_data_out,
  output logic                  memory_done,
  output logic                  mem_error,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp
);

  localparam int         OFF_W    = $clog2(STRB_WIDTH);
  localparam logic [2:0] BUS_SIZE = 3'(OFF_W);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] wsrc_q, wsrc_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic                  err_q, err_d;

  // rlast carries no information for single-beat reads.
  logic unused_rlast;
  assign unused_rlast = m_axi_rlast;

  // Request classification, only meaningful while IDLE.
  logic req_any, req_misaligned, req_illegal, req_bypass;
  always_comb begin
    req_misaligned = 1'b0;
    case (mem_size)
      2'd0:    req_misaligned = 1'b0;
      2'd1:    req_misaligned = alu_data[0];
      2'd2:    req_misaligned = |alu_data[1:0];
      default: req_misaligned = |alu_data[2:0];
    endcase
    req_illegal = (mem_size == 2'd3) && (DATA_WIDTH < 64);
    req_any     = mem_read || mem_write;
    req_bypass  = !req_any || req_misaligned || req_illegal;
  end

  logic [OFF_W-1:0] off;
  logic [OFF_W+2:0] bit_shift;
  assign off       = addr_q[OFF_W-1:0];
  assign bit_shift = {off, 3'b000};

  // Load formatting: shift the addressed lane down, keep the access width,
  // fill the rest with the lane's top bit for signed loads.
  logic [DATA_WIDTH-1:0] lane, keep_mask, load_ext;
  logic                  lane_sign;
  always_comb begin
    lane = m_axi_rdata >> bit_shift;
    case (size_q)
      2'd0: begin
        lane_sign = lane[7];
        keep_mask = DATA_WIDTH'(64'h0000_0000_0000_00FF);
      end
      2'd1: begin
        lane_sign = lane[15];
        keep_mask = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
      end
      2'd2: begin
        lane_sign = lane[31];
        keep_mask = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
      end
      default: begin
        lane_sign = lane[DATA_WIDTH-1];
        keep_mask = '1;
      end
    endcase
    load_ext = (lane & keep_mask) | ((lane_sign && !uns_q) ? ~keep_mask : '0);
  end

  // Store formatting.
  logic [7:0]            lanes_8;
  logic [STRB_WIDTH-1:0] strb_base;
  always_comb begin
    case (size_q)
      2'd0:    lanes_8 = 8'h01;
      2'd1:    lanes_8 = 8'h03;
      2'd2:    lanes_8 = 8'h0F;
      default: lanes_8 = 8'hFF;
    endcase
    strb_base = STRB_WIDTH'(lanes_8);
  end

  assign m_axi_araddr  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = BUS_SIZE;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = {1'b0, size_q};
  assign m_axi_wdata   = wsrc_q << bit_shift;
  assign m_axi_wstrb   = strb_base << off;
  assign m_axi_wlast   = 1'b1;

  assign loaded_data_out = load_q;
  assign mem_error       = err_q;

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (memory_enable) begin
          if (req_bypass)    state_d = S_DONE;
          else if (mem_read) state_d = S_RD_ADDR;
          else               state_d = S_WR_REQ;
        end
      end
      S_RD_ADDR: if (m_axi_arready) state_d = S_RD_DATA;
      S_RD_DATA: if (m_axi_rvalid)  state_d = S_DONE;
      S_WR_REQ: begin
        // A ready only counts while the matching valid is still up.
        if ((aw_done_q || m_axi_awready) && (w_done_q || m_axi_wready))
          state_d = S_WR_RESP;
      end
      S_WR_RESP: if (m_axi_bvalid) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, decoded from flops only
  always_comb begin
    m_axi_arvalid = (state_q == S_RD_ADDR);
    m_axi_rready  = (state_q == S_RD_DATA);
    m_axi_awvalid = (state_q == S_WR_REQ) && !aw_done_q;
    m_axi_wvalid  = (state_q == S_WR_REQ) && !w_done_q;
    m_axi_bready  = (state_q == S_WR_RESP);
    memory_done   = (state_q == S_DONE);
  end

  // Request latch and result registers
  always_comb begin
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wsrc_d    = wsrc_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    load_d    = load_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (memory_enable) begin
          addr_d    = alu_data;
          size_d    = mem_size;
          uns_d     = mem_unsigned;
          wsrc_d    = reg_b_contents;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_bypass) begin
            load_d = '0;
            err_d  = req_any;
          end
        end
      end
      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          load_d = load_ext;
          err_d  = (m_axi_rresp != 2'b00);
        end
      end
      S_WR_REQ: begin
        if (m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wready)  w_done_d  = 1'b1;
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          load_d = '0;
          err_d  = (m_axi_bresp != 2'b00);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      wsrc_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      load_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      wsrc_q    <= wsrc_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      load_q    <= load_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// tb_mem_access_unit
//   Drives mem_access_unit against a byte-array AXI slave and compares every
//   completion against a byte-level reference of the load/store rules.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        memory_enable, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [63:0] alu_data, reg_b_contents;
  logic [63:0] loaded_data_out;
  logic        memory_done, mem_error;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [63:0] m_axi_araddr, m_axi_awaddr, m_axi_rdata, m_axi_wdata;
  logic [7:0]  m_axi_arlen, m_axi_awlen, m_axi_wstrb;
  logic [2:0]  m_axi_arsize, m_axi_awsize;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic        m_axi_bvalid, m_axi_bready;

  mem_access_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) u_dut (
    .clk(clk), .reset(reset), .memory_enable(memory_enable), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .alu_data(alu_data), .reg_b_contents(reg_b_contents),
    .loaded_data_out(loaded_data_out), .memory_done(memory_done), .mem_error(mem_error),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
  );

  // 32-bit build, only used for the illegal double-size request.
  logic        en32, x32_done, x32_err;
  logic [31:0] x32_ldata, x32_wdata;
  logic        x32_arvalid, x32_rready, x32_awvalid, x32_wvalid, x32_wlast, x32_bready;
  logic [63:0] x32_araddr, x32_awaddr;
  logic [7:0]  x32_arlen, x32_awlen;
  logic [2:0]  x32_arsize, x32_awsize;
  logic [3:0]  x32_wstrb;

  mem_access_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .memory_enable(en32), .mem_read(1'b1),
    .mem_write(1'b0), .mem_size(2'd3), .mem_unsigned(1'b0),
    .alu_data(64'h100), .reg_b_contents(32'h0),
    .loaded_data_out(x32_ldata), .memory_done(x32_done), .mem_error(x32_err),
    .m_axi_arvalid(x32_arvalid), .m_axi_arready(1'b0), .m_axi_araddr(x32_araddr),
    .m_axi_arlen(x32_arlen), .m_axi_arsize(x32_arsize),
    .m_axi_rvalid(1'b0), .m_axi_rready(x32_rready), .m_axi_rdata(32'h0),
    .m_axi_rresp(2'b00), .m_axi_rlast(1'b0),
    .m_axi_awvalid(x32_awvalid), .m_axi_awready(1'b0), .m_axi_awaddr(x32_awaddr),
    .m_axi_awlen(x32_awlen), .m_axi_awsize(x32_awsize),
    .m_axi_wvalid(x32_wvalid), .m_axi_wready(1'b0), .m_axi_wdata(x32_wdata),
    .m_axi_wstrb(x32_wstrb), .m_axi_wlast(x32_wlast),
    .m_axi_bvalid(1'b0), .m_axi_bready(x32_bready), .m_axi_bresp(2'b00)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave and reference state ----------------
  logic [7:0]  slave_mem [256];
  logic [7:0]  ref_mem   [256];
  int          mode;        // 0 zero-wait, 1 random stalls, 2 awready lags wready by 4
  bit          r_block;
  logic [1:0]  rresp_inj, bresp_inj;
  logic [63:0] cur_addr, exp_wdata, exp_wmask;
  logic [1:0]  cur_size;
  logic [7:0]  exp_wstrb;
  bit          chk_indep;

  bit          ar_fire, r_fire, aw_fire, w_fire, b_fire;
  bit          r_pend, aw_got, w_got, b_pend;
  int          r_wait, b_wait, aw_cnt, ar_seen, aw_seen;
  logic [63:0] r_addr, cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [7:0]  cap_wstrb;

  function automatic int rand_wait();
    return (mode == 1) ? int'($urandom_range(0, 3)) : 0;
  endfunction

  function automatic logic [63:0] slave_word(input logic [63:0] a);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = slave_mem[(int'(a[7:0]) + j) % 256];
    return w;
  endfunction

  initial begin : axi_slave
    logic [63:0] base;
    {m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_awready, m_axi_wready, m_axi_bvalid} = '0;
    m_axi_rdata = '0; m_axi_rresp = '0; m_axi_bresp = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        {ar_fire, r_fire, aw_fire, w_fire, b_fire} = '0;
        {r_pend, aw_got, w_got, b_pend} = '0;
        aw_cnt = 0;
        {m_axi_arready, m_axi_rvalid, m_axi_awready, m_axi_wready, m_axi_bvalid} = '0;
      end else begin
        // handshakes completed on the last rising edge
        if (ar_fire) begin r_pend = 1; r_wait = rand_wait(); end
        if (r_fire)  r_pend = 0;
        if (b_fire)  b_pend = 0;
        if (aw_fire) aw_got = 1;
        if (w_fire)  w_got = 1;
        if (aw_got && w_got) begin
          base = cap_awaddr & ~64'h7;
          for (int j = 0; j < 8; j++)
            if (cap_wstrb[j]) slave_mem[(int'(base[7:0]) + j) % 256] = cap_wdata[8*j +: 8];
          aw_got = 0; w_got = 0; b_pend = 1; b_wait = rand_wait();
        end
        // drive this cycle
        m_axi_arready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_axi_arvalid) ar_seen++;
        m_axi_rvalid = 1'b0;
        if (r_pend) begin
          if (r_wait > 0) r_wait--;
          else if (!r_block) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = slave_word(r_addr);
            m_axi_rresp  = rresp_inj;
            m_axi_rlast  = 1'($urandom_range(0, 1));
          end
        end
        if (m_axi_awvalid) aw_seen++;
        if (mode == 2) m_axi_awready = m_axi_awvalid && (aw_cnt >= 4);
        else m_axi_awready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_axi_awvalid) aw_cnt++;
        m_axi_wready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_bvalid = 1'b0;
        if (b_pend) begin
          if (b_wait > 0) b_wait--;
          else begin m_axi_bvalid = 1'b1; m_axi_bresp = bresp_inj; end
        end
        ar_fire = m_axi_arvalid && m_axi_arready;
        r_fire  = m_axi_rvalid && m_axi_rready;
        aw_fire = m_axi_awvalid && m_axi_awready;
        w_fire  = m_axi_wvalid && m_axi_wready;
        b_fire  = m_axi_bvalid && m_axi_bready;
        if (ar_fire) begin
          r_addr = m_axi_araddr; cap_araddr = m_axi_araddr; cap_arsize = m_axi_arsize;
          check_val("araddr", m_axi_araddr, cur_addr & ~64'h7);
          check_val("arsize", m_axi_arsize, 3);
          check_val("arlen", m_axi_arlen, 0);
        end
        if (aw_fire) begin
          cap_awaddr = m_axi_awaddr; cap_awsize = m_axi_awsize; aw_cnt = 0;
          check_val("awaddr", m_axi_awaddr, cur_addr);
          check_val("awsize", m_axi_awsize, cur_size);
          check_val("awlen", m_axi_awlen, 0);
        end
        if (w_fire) begin
          cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb;
          check_val("wstrb", m_axi_wstrb, exp_wstrb);
          check_val("wdata", m_axi_wdata & exp_wmask, exp_wdata);
          check_val("wlast", m_axi_wlast, 1);
        end
      end
    end
  end

  // Byte-level reference: loads assemble little-endian bytes, stores scatter them.
  task automatic ref_access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                            input logic [63:0] addr, input logic [63:0] data,
                            output logic [63:0] exp_d, output logic exp_e, output bit bus);
    int nb, lane0, idx;
    longint unsigned v;
    nb = 1 << sz;
    exp_d = 0; exp_e = 0; bus = 0;
    exp_wdata = 0; exp_wmask = 0; exp_wstrb = 0;
    if (!rd && !wr) return;
    if ((addr % nb) != 0) begin exp_e = 1; return; end
    bus = 1;
    lane0 = int'(addr % 8);
    if (rd) begin
      v = 0;
      for (int k = 0; k < nb; k++) begin
        idx = (int'(addr[7:0]) + k) % 256;
        v = v | (longint'(ref_mem[idx]) << (8 * k));
      end
      if (!uns && nb < 8 && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
      exp_d = v;
      exp_e = (rresp_inj != 0);
    end else begin
      for (int k = 0; k < nb; k++) begin
        idx = (int'(addr[7:0]) + k) % 256;
        ref_mem[idx] = data[8*k +: 8];
        exp_wdata = exp_wdata | (64'(data[8*k +: 8]) << (8 * (lane0 + k)));
        exp_wmask = exp_wmask | (64'hFF << (8 * (lane0 + k)));
        exp_wstrb = exp_wstrb | (8'h01 << (lane0 + k));
      end
      exp_e = (bresp_inj != 0);
    end
  endtask

  task automatic poke(input logic [63:0] addr, input logic [7:0] val);
    slave_mem[addr[7:0]] = val;
    ref_mem[addr[7:0]]   = val;
  endtask

  // Issue one request at a falling edge; returns cycles from accept to done.
  task automatic run_access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                            input logic [63:0] addr, input logic [63:0] data,
                            input bit scramble, output int lat);
    logic [63:0] exp_d;
    logic        exp_e;
    bit          bus;
    int          n;
    cur_addr = addr; cur_size = sz; ar_seen = 0; aw_seen = 0;
    ref_access(rd, wr, sz, uns, addr, data, exp_d, exp_e, bus);
    memory_enable = 1; mem_read = rd; mem_write = wr; mem_size = sz;
    mem_unsigned = uns; alu_data = addr; reg_b_contents = data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!memory_done) begin
        if (chk_indep && n == 2) begin
          check_val("w_dropped", m_axi_wvalid, 0);
          check_val("aw_held", m_axi_awvalid, 1);
        end
        if (scramble) begin
          alu_data = {$urandom, $urandom}; reg_b_contents = {$urandom, $urandom};
          mem_size = 2'($urandom_range(0, 3)); mem_unsigned = 1'($urandom_range(0, 1));
          mem_read = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
        end
      end
    end while (!memory_done && n < 200);
    memory_enable = 0;
    check_val("done", memory_done, 1);
    check_val("ldata", loaded_data_out, exp_d);
    check_val("err", mem_error, exp_e);
    if (!bus) check_val("no_bus", 64'(ar_seen + aw_seen), 0);
    lat = n;
    @(negedge clk);
    check_val("done_pulse", memory_done, 0);
    check_val("hold_data", loaded_data_out, exp_d);
    check_val("hold_err", mem_error, exp_e);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, n, op;
    logic [5:0] pulses;
    logic [1:0] sz;
    logic [63:0] a;
    memory_enable = 0; mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0;
    alu_data = 0; reg_b_contents = 0; en32 = 0;
    mode = 0; r_block = 0; rresp_inj = 0; bresp_inj = 0; chk_indep = 0;
    cur_addr = 0; cur_size = 0;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i]   = slave_mem[i];
    end

    repeat (3) @(negedge clk);
    check_val("rst_outs", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
                           m_axi_bready, memory_done, mem_error}, 0);
    check_val("rst_ldata", loaded_data_out, 0);
    reset = 1;
    @(negedge clk);

    // sub-word loads with sign/zero extension
    poke(64'h1003, 8'h80);
    run_access(1, 0, 2'd0, 0, 64'h1003, 0, 0, lat);
    check_val("lb_s_data", loaded_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    check_val("lb_araddr", cap_araddr, 64'h1000);
    check_val("lb_arsize", cap_arsize, 3);
    check_val("lb_lat", lat, 3);
    run_access(1, 0, 2'd0, 1, 64'h1003, 0, 0, lat);
    check_val("lb_u_data", loaded_data_out, 64'h80);
    poke(64'h1003, 8'h00);
    run_access(1, 0, 2'd0, 0, 64'h1003, 0, 0, lat);
    check_val("lb_zero", loaded_data_out, 0);

    // store half, zero-wait then awready lagging
    run_access(0, 1, 2'd1, 0, 64'h2006, 64'hBEEF, 0, lat);
    check_val("sh_awaddr", cap_awaddr, 64'h2006);
    check_val("sh_awsize", cap_awsize, 1);
    check_val("sh_wstrb", cap_wstrb, 8'hC0);
    check_val("sh_wdata", cap_wdata[63:48], 16'hBEEF);
    check_val("sh_lat", lat, 3);
    mode = 2; chk_indep = 1;
    run_access(0, 1, 2'd1, 0, 64'h2006, 64'h1234, 0, lat);
    check_val("sh_lag_lat", lat, 7);
    mode = 0; chk_indep = 0;
    run_access(1, 0, 2'd1, 1, 64'h2006, 0, 0, lat);
    check_val("lh_back", loaded_data_out, 64'h1234);

    // misaligned word
    run_access(1, 0, 2'd2, 0, 64'h3002, 0, 0, lat);
    check_val("mis_lat", lat, 1);
    check_val("mis_err", mem_error, 1);
    check_val("mis_noar", ar_seen, 0);

    // bus errors
    rresp_inj = 2;
    run_access(1, 0, 2'd3, 0, 64'h4008, 0, 0, lat);
    check_val("rresp_err", mem_error, 1);
    rresp_inj = 0; bresp_inj = 3;
    run_access(0, 1, 2'd2, 0, 64'h4010, 64'hCAFE_F00D, 0, lat);
    check_val("bresp_err", mem_error, 1);
    check_val("bresp_ldata", loaded_data_out, 0);
    bresp_inj = 0;

    // reset while waiting for the read beat (leave nonzero load data first)
    poke(64'h50, 8'hA5);
    run_access(1, 0, 2'd0, 1, 64'h50, 0, 0, lat);
    r_block = 1; cur_addr = 64'h48; cur_size = 3;
    memory_enable = 1; mem_read = 1; mem_write = 0; mem_size = 3; alu_data = 64'h48;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_axi_rready && n < 20);
    check_val("mid_rready", m_axi_rready, 1);
    #2 reset = 0;
    #1;
    check_val("mid_rst_outs", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
                               m_axi_bready, memory_done, mem_error}, 0);
    check_val("mid_rst_ldata", loaded_data_out, 0);
    memory_enable = 0;
    @(negedge clk); @(negedge clk);
    r_block = 0; reset = 1;
    @(negedge clk);
    run_access(1, 0, 2'd3, 0, 64'h48, 0, 0, lat);
    check_val("post_rst_lat", lat, 3);

    // back-to-back no-ops
    memory_enable = 1; mem_read = 0; mem_write = 0; alu_data = 64'h7;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulses[i] = memory_done;
      if (memory_done) check_val("noop_data", loaded_data_out, 0);
    end
    memory_enable = 0;
    check_val("noop_pulses", pulses, 6'b010101);
    @(negedge clk);

    // 32-bit build rejects double size
    en32 = 1;
    @(negedge clk);
    check_val("dw32_done", x32_done, 1);
    check_val("dw32_err", x32_err, 1);
    check_val("dw32_noar", x32_arvalid, 0);
    en32 = 0;
    @(negedge clk);

    // randomized traffic with stalls and request scrambling after accept
    mode = 1;
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 7);
      sz = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) a = a & ~((64'd1 << sz) - 1);
      rresp_inj = ($urandom_range(0, 7) == 0) ? 2'd2 : 2'd0;
      bresp_inj = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      run_access(op == 1 || (op >= 2 && op <= 4), op == 1 || op >= 5, sz,
                 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 1, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
